// File: rtl/fc_argmax_if.sv
// Stream, ROM and result signals of the fc_argmax classifier stage.
// The block is the slave; the surrounding pipeline and the weight ROM form the master side.
interface fc_argmax_if #(
  parameter int DW   = 32,
  parameter int WW   = 8,
  parameter int AW   = 10,
  parameter int NCLS = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DW-1:0]      in_data;
  logic [AW-1:0]             rom_addr;
  logic signed [WW-1:0]      rom_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(NCLS)-1:0]   out_class;
  logic signed [DW-1:0]      out_score;

  modport slave (
    input  in_valid, in_data, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_class, out_score
  );

  modport master (
    output in_valid, in_data, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_class, out_score
  );
endinterface

// File: rtl/fc_argmax.sv
// Fully-connected classifier with argmax: buffers CH inputs, computes NCLS logits from ROM weights.
// Define FC_SAT_EN to saturate scores to DW bits; otherwise scores wrap to the low DW bits.
module fc_argmax #(
  parameter int CH   = 56,
  parameter int NCLS = 10,
  parameter int DW   = 32,
  parameter int WW   = 8,
  parameter int FRAC = 7,
  parameter int AW   = 10
) (
  input  logic      clk,
  input  logic      rst,
  fc_argmax_if.slave bus
);
  localparam int CW   = $clog2(NCLS);
  localparam int KW   = $clog2(CH + 2);
  localparam int ACCW = 48;
  localparam int PW   = DW + WW;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, CMP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cls_q, cls_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [AW-1:0]           rom_addr_q, rom_addr_d;
  logic [CW-1:0]           best_cls_q, best_cls_d;
  logic signed [DW-1:0]    best_score_q, best_score_d;
  logic                    buf_we;

  logic signed [DW-1:0]    buf_q [CH];
  logic [KW-1:0]           kidx;
  logic signed [DW-1:0]    mac_x;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  bias_ext;
  logic signed [DW-1:0]    score;

  function automatic logic signed [DW-1:0] reduce_score(input logic signed [ACCW-1:0] a);
`ifdef FC_SAT_EN
    logic signed [ACCW-1:0] s;
    logic signed [ACCW-1:0] smax;
    logic signed [ACCW-1:0] smin;
    s    = a >>> FRAC;
    smax = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    smin = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (s > smax)      return {1'b0, {(DW-1){1'b1}}};
    else if (s < smin) return {1'b1, {(DW-1){1'b0}}};
    else               return s[DW-1:0];
`else
    return DW'(a >>> FRAC);
`endif
  endfunction

  // Weight k arrives on rom_data during MAC cycle k+1, so the buffer is read one behind the counter.
  assign kidx     = cnt_q - KW'(1);
  assign mac_x    = buf_q[kidx];
  assign prod     = PW'(mac_x) * PW'(bus.rom_data);
  assign bias_ext = ACCW'(bus.rom_data) <<< FRAC;
  assign score    = reduce_score(acc_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cls_d        = cls_q;
    acc_d        = acc_q;
    rom_addr_d   = rom_addr_q;
    best_cls_d   = best_cls_q;
    best_score_d = best_score_q;
    buf_we       = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: begin
        if (bus.in_valid) begin
          buf_we = 1'b1;
          if (cnt_q == KW'(CH - 1)) begin
            state_d    = MAC;
            cnt_d      = '0;
            cls_d      = '0;
            rom_addr_d = '0;
          end else begin
            cnt_d = cnt_q + KW'(1);
          end
        end
      end
      MAC: begin
        if (cnt_q == '0)              acc_d = '0;
        else if (cnt_q <= KW'(CH))    acc_d = acc_q + ACCW'(prod);
        else                          acc_d = acc_q + bias_ext;
        if (cnt_q < KW'(CH)) rom_addr_d = rom_addr_q + AW'(1);
        if (cnt_q == KW'(CH + 1)) begin
          state_d = CMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      CMP: begin
        // Strict compare: ties keep the lower class index.
        if (cls_q == '0 || score > best_score_q) begin
          best_cls_d   = cls_q;
          best_score_d = score;
        end
        if (cls_q == CW'(NCLS - 1)) begin
          state_d = DONE;
        end else begin
          cls_d      = cls_q + CW'(1);
          rom_addr_d = rom_addr_q + AW'(1);
          state_d    = MAC;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cls_q        <= '0;
      acc_q        <= '0;
      rom_addr_q   <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cls_q        <= cls_d;
      acc_q        <= acc_d;
      rom_addr_q   <= rom_addr_d;
      best_cls_q   <= best_cls_d;
      best_score_q <= best_score_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q] <= bus.in_data;
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DONE);
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_class = best_cls_q;
  assign bus.out_score = best_score_q;
endmodule
